// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the 7-segment scanner
// Purpose: blank/off codes, digit-index width helper and the hex -> 7-segment
//          active-low lookup table ([6:0] = g,f,e,d,c,b,a).
// Ports:   none (package).
package seg7_pkg;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the active-low pattern for hex digit n (entry 0 is rightmost).
    localparam logic [15:0][6:0] HEX_SEG7_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Width of a digit index register for a display with 'digits' positions.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
// Purpose: maps one 4-bit hex value to the g..a segment pattern.
// Ports:   hex in [3:0] nibble to decode
//          seg out [6:0] active-low segments g,f,e,d,c,b,a
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG7_TABLE[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment scanner with tear-free frame capture
// Purpose: latches the hex word once per frame, scans DIGITS digits with SCAN_DIV cycles per
//          slot, keeps all anodes off for the first BLANK_CYC cycles of a slot, pulses
//          frame_tick when a new word is captured.
// Option:  SEG7_LEADING_ZERO_BLANK_EN - blank leading zero digits (digit 0 never blanked,
//          a lit decimal point stops the blanking).
// Ports:   clk        in  system clock
//          rst        in  synchronous reset, active-high
//          value      in  [4*DIGITS-1:0] hex word, digit 0 = value[3:0]
//          dp_mask    in  [DIGITS-1:0] 1 = light decimal point of digit i
//          anode      out [DIGITS-1:0] active-low digit enables
//          segment    out [7:0] active-low, [7]=dp, [6:0]=g..a
//          frame_tick out one-cycle pulse on frame capture
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            segment,
    output logic                  frame_tick
);

    localparam int IW = idx_width(DIGITS);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0]         div_cnt;
    logic [IW-1:0]         digit_idx;
    logic [4*DIGITS-1:0]   frame_val;
    logic [DIGITS-1:0]     frame_dp;

    logic                  slot_wrap;
    logic                  last_digit;
    logic [3:0]            cur_nibble;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_lo;
    logic [DIGITS-1:0]     lz_blank;

    assign slot_wrap  = (div_cnt == CW'(SCAN_DIV - 1));
    assign last_digit = (digit_idx == IW'(DIGITS - 1));
    assign cur_nibble = frame_val[{digit_idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .hex (cur_nibble),
        .seg (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; blanking holds while every digit seen so
    // far is zero with its dp off. Digit 0 is outside the walk, so never blank.
    always_comb begin
        logic still_zero;
        lz_blank   = '0;
        still_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            still_zero  = still_zero & (frame_val[4*i +: 4] == 4'h0) & ~frame_dp[i];
            lz_blank[i] = still_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign seg_lo = lz_blank[digit_idx] ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            digit_idx  <= '0;
            anode      <= '1;
            segment    <= SEG_OFF;
            frame_tick <= 1'b0;
            frame_val  <= value;
            frame_dp   <= dp_mask;
        end else begin
            // Anti-ghosting gap: the first BLANK_CYC cycles of every slot keep
            // all digits dark while the segment lines settle to the new digit.
            anode      <= (div_cnt < CW'(BLANK_CYC)) ? '1
                                                     : ~(DIGITS'(1) << digit_idx);
            segment    <= {~frame_dp[digit_idx], seg_lo};
            frame_tick <= slot_wrap & last_digit;

            if (slot_wrap) begin
                div_cnt <= '0;
                if (last_digit) begin
                    digit_idx <= '0;
                    frame_val <= value;
                    frame_dp  <= dp_mask;
                end else begin
                    digit_idx <= digit_idx + IW'(1);
                end
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BL = 1;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  anode;
    logic [7:0]  segment;
    logic        frame_tick;

    int total = 0;
    int fails = 0;

    // Reference model: n = clock edges since reset released; the frame word
    // shown is the one latched at reset or at the end of the previous frame.
    int          n = 0;
    logic [15:0] m_frame = '0;
    logic [3:0]  m_dp = '0;

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_mask    (dp_mask),
        .anode      (anode),
        .segment    (segment),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int slot);
        logic [6:0] lo;
        logic [3:0] nib;
        nib = m_frame[4*slot +: 4];
        lo  = DEC[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            int lim;
            lim = 0;
            for (int i = 0; i < D; i++)
                if (m_frame[4*i +: 4] != 4'h0 || m_dp[i]) lim = i;
            if (slot > lim) lo = 7'h7F;
        end
`endif
        return {~m_dp[slot], lo};
    endfunction

    task automatic step();
        logic [3:0]  ea;
        logic [7:0]  es;
        logic        et;
        int          slot;
        int          pos;
        @(posedge clk);
        if (rst) begin
            ea = 4'hF; es = 8'hFF; et = 1'b0;
            m_frame = value; m_dp = dp_mask; n = 0;
        end else begin
            slot = (n / SD) % D;
            pos  = n % SD;
            ea   = (pos < BL) ? 4'hF : ~(4'b0001 << slot);
            es   = exp_seg(slot);
            et   = (slot == D - 1) && (pos == SD - 1);
            if (et) begin
                m_frame = value; m_dp = dp_mask;
            end
            n++;
        end
        #1;
        chk("model_anode", {4'h0, anode}, {4'h0, ea});
        chk("model_segment", segment, es);
        chk("model_tick", {7'd0, frame_tick}, {7'd0, et});
        chk("one_anode_low", {7'd0, ($countones(~anode) <= 1)}, 8'd1);
    endtask

    task automatic restart(input logic [15:0] v, input logic [3:0] dp);
        rst = 1'b1; value = v; dp_mask = dp;
        step();
        chk("rst_anode", {4'h0, anode}, 8'h0F);
        chk("rst_segment", segment, 8'hFF);
        chk("rst_tick", {7'd0, frame_tick}, 8'd0);
        rst = 1'b0;
    endtask

    // Runs one full frame from its first edge; e0..e3 are the expected
    // segment bytes of digits 0..3, value switches to midval mid-frame.
    task automatic frame_literal(input logic [15:0] midval,
                                 input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        logic [3:0] ea;
        e = '{e0, e1, e2, e3};
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 5) value = midval;
            if (k % 4 == 1) chk("slot_blank_anode", {4'h0, anode}, 8'h0F);
            if (k % 4 == 2) begin
                ea = ~(4'b0001 << (k / 4));
                chk("slot_anode", {4'h0, anode}, {4'h0, ea});
                chk("slot_segment", segment, e[k / 4]);
            end
            chk("frame_tick", {7'd0, frame_tick}, {7'd0, (k == 16)});
        end
    endtask

    initial begin
        logic [7:0] z;
        z = LZ ? 8'hFF : 8'hC0;
        rst = 1'b1; value = 16'h1234; dp_mask = 4'h0;
        repeat (3) begin
            step();
            chk("rst_anode", {4'h0, anode}, 8'h0F);
            chk("rst_segment", segment, 8'hFF);
            chk("rst_tick", {7'd0, frame_tick}, 8'd0);
        end
        rst = 1'b0;

        frame_literal(16'hABCD, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        dp_mask = 4'b0100;
        frame_literal(16'hABCD, 8'hA1, 8'hC6, 8'h83, 8'h88);
        frame_literal(16'hABCD, 8'hA1, 8'hC6, 8'h03, 8'h88);

        repeat (10) step();
        rst = 1'b1; value = 16'h5678; dp_mask = 4'h0;
        step();
        chk("midrst_anode", {4'h0, anode}, 8'h0F);
        chk("midrst_segment", segment, 8'hFF);
        rst = 1'b0;
        frame_literal(16'h5678, 8'h80, 8'hF8, 8'h82, 8'h92);

        restart(16'h0050, 4'h0);
        frame_literal(16'h0050, 8'hC0, 8'h92, z, z);
        restart(16'h0000, 4'h0);
        frame_literal(16'h0000, 8'hC0, z, z, z);
        restart(16'h0005, 4'b1000);
        frame_literal(16'h0005, 8'h92, 8'hC0, 8'hC0, 8'h40);

        for (int i = 0; i < 600; i++) begin
            step();
            if ($urandom_range(0, 19) == 0) value = 16'($urandom);
            if ($urandom_range(0, 29) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) value = 16'($urandom_range(0, 15) << (4 * $urandom_range(0, 3)));
            rst = ($urandom_range(0, 79) == 0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
